// File: rtl/parity_pkg.sv
// Shared definitions for the parity pipeline: parity mode constants and
// the lane parity function used by every parity_lane instance.
package parity_pkg;

    // Beat-level parity mode carried on in_odd.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest lane the helper accepts; narrower lanes are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int MAX_WIDTH = 1024;

    // Even parity is the XOR of all bits; odd mode inverts it.
    function automatic logic lane_parity(
        input logic [MAX_WIDTH-1:0] data,
        input logic                 mode
    );
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/parity_lane.sv
// Combinational parity generator/checker for one WIDTH-bit lane.
// Ports: data, mode (0 even / 1 odd), rx_parity in; parity, error out.
module parity_lane
    import parity_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    input  logic             rx_parity,
    output logic             parity,
    output logic             error
);

    assign parity = lane_parity(MAX_WIDTH'(data), mode);
    assign error  = parity ^ rx_parity;

endmodule

// File: rtl/parity_pipe.sv
// One-stage valid/ready parity pipeline: generates per-lane parity,
// checks it against in_parity, and tracks errors with a sticky flag.
// Ports: clk, rst_x (async active-low); in_valid/in_ready/in_data/
// in_parity/in_odd upstream; out_valid/out_ready/out_data/out_parity/
// out_error downstream; err_clear, err_sticky, err_count status.
// Define PARITY_PIPE_ERR_COUNT_EN to build the saturating error counter;
// otherwise err_count is tied to zero.
module parity_pipe
    import parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_x,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_parity,
    input  logic                   in_odd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_parity,
    output logic [LANES-1:0]       out_error,
    input  logic                   err_clear,
    output logic                   err_sticky,
    output logic [CNT_W-1:0]       err_count
);

    logic [LANES-1:0] gen_parity;
    logic [LANES-1:0] gen_error;
    logic             accept;
    logic             beat_err;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        parity_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .data     (in_data[l*WIDTH +: WIDTH]),
            .mode     (in_odd),
            .rx_parity(in_parity[l]),
            .parity   (gen_parity[l]),
            .error    (gen_error[l])
        );
    end

    // The output register frees up when empty or being drained.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    // One errored beat counts once, however many lanes mismatch.
    assign beat_err = accept & (|gen_error);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= '0;
            out_error  <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_parity <= gen_parity;
            out_error  <= gen_error;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // A clear coinciding with an errored beat keeps that beat's error.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            err_sticky <= 1'b0;
        end else if (err_clear) begin
            err_sticky <= beat_err;
        end else if (beat_err) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef PARITY_PIPE_ERR_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cnt <= '0;
        end else if (err_clear) begin
            cnt <= CNT_W'(beat_err);
        end else if (beat_err && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign err_count = cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_pipe.sv
// Self-checking bench for parity_pipe: default instance plus a CNT_W=2
// instance sharing stimulus, compared every cycle against a behavioural model.
module tb_parity_pipe;

    localparam int W   = 8;
    localparam int L   = 4;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic          clk = 1'b0;
    logic          rst_x = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic [3:0]    in_parity = '0;
    logic          in_odd = 1'b0;
    logic          out_ready = 1'b1;
    logic          err_clear = 1'b0;

    logic          in_ready_a, out_valid_a, err_sticky_a;
    logic [31:0]   out_data_a;
    logic [3:0]    out_parity_a, out_error_a;
    logic [CW-1:0] err_count_a;

    logic           in_ready_b, out_valid_b, err_sticky_b;
    logic [31:0]    out_data_b;
    logic [3:0]     out_parity_b, out_error_b;
    logic [CWS-1:0] err_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_x(rst_x),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_parity(in_parity), .in_odd(in_odd),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_parity(out_parity_a),
        .out_error(out_error_a), .err_clear(err_clear),
        .err_sticky(err_sticky_a), .err_count(err_count_a)
    );

    parity_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CWS)) u_sat (
        .clk(clk), .rst_x(rst_x),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_parity(in_parity), .in_odd(in_odd),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_parity(out_parity_b),
        .out_error(out_error_b), .err_clear(err_clear),
        .err_sticky(err_sticky_b), .err_count(err_count_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Parity rule: count of ones per lane, mod 2, flipped in odd mode.
    function automatic logic [3:0] gen_par(input logic [31:0] d, input logic odd);
        logic [3:0] p;
        for (int l = 0; l < L; l++)
            p[l] = logic'(($countones(d[l*W +: W]) % 2) == 1) ^ odd;
        return p;
    endfunction

    function automatic int exp_cnt(input int m);
`ifdef PARITY_PIPE_ERR_COUNT_EN
        return m;
`else
        return 0;
`endif
    endfunction

    // Behavioural model: one held output beat plus error bookkeeping.
    bit         mv = 0;
    logic [31:0] md = '0;
    logic [3:0]  mp = '0, me = '0;
    bit         msticky = 0;
    int         mcnt_a = 0, mcnt_b = 0;
    bit         m_rdy, m_acc, m_berr;
    logic [3:0] m_p;

    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            mv = 0; md = '0; mp = '0; me = '0;
            msticky = 0; mcnt_a = 0; mcnt_b = 0;
        end else begin
            m_rdy  = !mv || out_ready;
            m_acc  = in_valid && m_rdy;
            m_p    = gen_par(in_data, in_odd);
            m_berr = m_acc && ((m_p ^ in_parity) != 4'b0);
            if (m_acc) begin
                mv = 1; md = in_data; mp = m_p; me = m_p ^ in_parity;
            end else if (out_ready) begin
                mv = 0;
            end
            if (err_clear) begin
                msticky = m_berr; mcnt_a = int'(m_berr); mcnt_b = int'(m_berr);
            end else if (m_berr) begin
                msticky = 1;
                if (mcnt_a < (1 << CW) - 1) mcnt_a++;
                if (mcnt_b < (1 << CWS) - 1) mcnt_b++;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready_a}, {31'b0, !mv || out_ready});
        chk("in_ready_sat", {31'b0, in_ready_b}, {31'b0, !mv || out_ready});
        chk("out_valid", {31'b0, out_valid_a}, {31'b0, mv});
        chk("out_valid_sat", {31'b0, out_valid_b}, {31'b0, mv});
        if (mv) begin
            chk("out_data", out_data_a, md);
            chk("out_parity", {28'b0, out_parity_a}, {28'b0, mp});
            chk("out_error", {28'b0, out_error_a}, {28'b0, me});
            chk("out_error_sat", {28'b0, out_error_b}, {28'b0, me});
        end
        chk("err_sticky", {31'b0, err_sticky_a}, {31'b0, msticky});
        chk("err_sticky_sat", {31'b0, err_sticky_b}, {31'b0, msticky});
        chk("err_count", 32'(err_count_a), 32'(exp_cnt(mcnt_a)));
        chk("err_count_sat", 32'(err_count_b), 32'(exp_cnt(mcnt_b)));
    end

    // Present a beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic [3:0] p, input logic odd);
        bit r;
        int n;
        in_valid = 1'b1; in_data = d; in_parity = p; in_odd = odd;
        n = 0;
        do begin
            #1 r = in_ready_a;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 50);
        if (!r) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
    endtask

    logic [31:0] a_beat, b_beat, d;
    logic [3:0]  pe, po;
    logic [7:0]  i8;

    initial begin
        #1;
        chk("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
        chk("rst_out_data", out_data_a, 32'd0);
        chk("rst_err_count", 32'(err_count_a), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_x = 1'b1;
        @(posedge clk); #1;

        // Generation
        send(32'h0811_00FF, 4'b1000, 1'b0);
        @(negedge clk);
        chk("gen_even", {28'b0, out_parity_a}, 32'h8);
        chk("model_even", {28'b0, mp}, 32'h8);
        send(32'h0811_00FF, 4'b0111, 1'b1);
        @(negedge clk);
        chk("gen_odd", {28'b0, out_parity_a}, 32'h7);

        // Error capture
        send(32'h0811_00FF, 4'b1100, 1'b0);
        @(negedge clk);
        chk("err_lanes", {28'b0, out_error_a}, 32'h4);
        chk("err_sticky_set", {31'b0, err_sticky_a}, 32'd1);
        chk("err_count_one", 32'(err_count_a), 32'(exp_cnt(1)));

        // Backpressure
        @(posedge clk); #1;
        a_beat = 32'hA5A5_1234;
        b_beat = 32'h5A5A_C3C3;
        send(a_beat, gen_par(a_beat, 1'b0), 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = b_beat;
        in_parity = gen_par(b_beat, 1'b0); in_odd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready_a}, 32'd0);
            chk("bp_hold", out_data_a, a_beat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'b0, out_valid_a}, 32'd1);
        chk("bp_next_data", out_data_a, b_beat);

        // Sweep with correct parity
        clear_pulse();
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            d = {4{i8}};
            send(d, gen_par(d, 1'b0), 1'b0);
            @(negedge clk);
            pe = out_parity_a;
            chk("sweep_err_even", {28'b0, out_error_a}, 32'd0);
            send(d, gen_par(d, 1'b1), 1'b1);
            @(negedge clk);
            po = out_parity_a;
            chk("sweep_compl", {28'b0, po}, {28'b0, ~pe});
        end
        chk("sweep_count", 32'(err_count_a), 32'd0);
        chk("sweep_sticky", {31'b0, err_sticky_a}, 32'd0);

        // Saturation and clear
        @(posedge clk); #1;
        clear_pulse();
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            send(d, ~gen_par(d, 1'b0), 1'b0);
        end
        @(negedge clk);
        chk("sat_small", 32'(err_count_b), 32'(exp_cnt(3)));
        chk("sat_big", 32'(err_count_a), 32'(exp_cnt(5)));
        @(posedge clk); #1;
        err_clear = 1'b1;
        send(32'h0000_0001, 4'b0000, 1'b0);
        err_clear = 1'b0;
        @(negedge clk);
        chk("clr_err_count", 32'(err_count_b), 32'(exp_cnt(1)));
        chk("clr_err_sticky", {31'b0, err_sticky_b}, 32'd1);

        // Randomized traffic
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            d = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = d;
            in_odd    = 1'($urandom_range(0, 1));
            in_parity = ($urandom_range(0, 1) != 0) ? gen_par(d, in_odd) : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; err_clear = 1'b0; out_ready = 1'b1;

        // Reset mid-stream with a held, errored beat
        @(posedge clk); #1;
        send(32'h0000_00FF, 4'b1111, 1'b0);
        out_ready = 1'b0;
        @(posedge clk); #2;
        rst_x = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid_a}, 32'd0);
        chk("mid_rst_sticky", {31'b0, err_sticky_a}, 32'd0);
        chk("mid_rst_count", 32'(err_count_a), 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready_a}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hC0DE_0042;
        in_parity = gen_par(32'hC0DE_0042, 1'b0); in_odd = 1'b0;
        @(negedge clk) rst_x = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, out_valid_a}, 32'd1);
        chk("post_rst_data", out_data_a, 32'hC0DE_0042);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_pipe.md
PARITY_PIPE -- requirements
Module: parity_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per lane (>=1).
REQ-002 SHALL have parameter LANES, default 4, independent parity lanes (>=1).
REQ-003 SHALL have parameter CNT_W, default 16, error counter width (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_x  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat.
REQ-008 SHALL have port in_data  input  LANES*WIDTH  lane l at bits [l*WIDTH +: WIDTH].
REQ-009 SHALL have port in_parity  input  LANES  received parity per lane, checked.
REQ-010 SHALL have port in_odd  input  1  per-beat mode: 0 even, 1 odd.
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port out_data  output  LANES*WIDTH  registered copy of in_data.
REQ-014 SHALL have port out_parity  output  LANES  generated parity per lane.
REQ-015 SHALL have port out_error  output  LANES  per-lane mismatch, generated vs in_parity.
REQ-016 SHALL have port err_clear  input  1  synchronous clear of sticky flag and counter.
REQ-017 SHALL have port err_sticky  output  1  set once any lane error is captured.
REQ-018 SHALL have port err_count  output  CNT_W  errored beats captured, saturating.

Function
REQ-019 SHALL accept a beat on any rising edge with in_valid=1 and in_ready=1.
REQ-020 SHALL drive in_ready = !out_valid | out_ready (combinational); full throughput, one beat per cycle.
REQ-021 SHALL present an accepted beat on out_* exactly 1 cycle after acceptance (latency 1).
REQ-022 SHALL hold out_data/out_parity/out_error stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after out_valid&out_ready with no new accept; accept+drain in one cycle keeps out_valid=1 with new data.
REQ-024 SHALL compute out_parity[l] = XOR of lane l, inverted when in_odd=1 (sampled with the beat).
REQ-025 SHALL compute out_error[l] = out_parity[l] XOR in_parity[l], registered with the beat.
REQ-026 SHALL set err_sticky and increment err_count by exactly 1 at acceptance of a beat with any lane error, regardless of lane count in error.
REQ-027 SHALL saturate err_count at 2^CNT_W-1; no wrap.
REQ-028 SHALL on err_clear=1 zero err_sticky and err_count next edge; simultaneous errored accept leaves err_sticky=1, err_count=1.
REQ-029 SHALL ignore in_* when in_ready=0; no beat lost or duplicated.

Reset
REQ-030 SHALL asynchronously on rst_x=0 force out_valid=0, out_data=0, out_parity=0, out_error=0, err_sticky=0, err_count=0.
REQ-031 SHALL drop any in-flight beat on reset mid-operation; in_ready=1 during reset; first accept on first edge after rst_x rises.

Configuration
REQ-032 SHALL compile err_count logic only when PARITY_PIPE_ERR_COUNT_EN is defined.
REQ-033 SHALL without PARITY_PIPE_ERR_COUNT_EN tie err_count to 0 with no counter flops; err_sticky, err_clear unchanged.

Structure
REQ-034 SHALL place mode constants (PARITY_EVEN=0, PARITY_ODD=1) and lane-parity function in shared package parity_pkg.
REQ-035 SHALL instantiate LANES copies of sub-module parity_lane (combinational WIDTH-bit generator/checker: data, mode, rx parity -> parity, error).

Verification (WIDTH=8, LANES=4, CNT_W=16 unless stated)
REQ-036 SHALL check reset: rst_x=0 mid-stream -> out_valid=0, err_sticky=0, err_count=0, in_ready=1 immediately.
REQ-037 SHALL check generation: in_data=32'h0811_00FF, in_odd=0 -> out_parity=4'b1000 next cycle; in_odd=1 -> 4'b0111.
REQ-038 SHALL check backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data constant; out_ready=1 -> drain, next beat 1 cycle later.
REQ-039 SHALL check error: in_data=32'h0811_00FF, in_odd=0, in_parity=4'b1100 -> out_error=4'b0100, err_sticky=1, err_count=1.
REQ-040 SHALL check sweep: i=0..255 replicated per lane, both modes, correct in_parity -> out_error=0, err_count=0, even/odd out_parity bitwise complementary.
REQ-041 SHALL check saturation/clear: CNT_W=2, 5 errored beats -> err_count=3; err_clear with errored beat same cycle -> err_count=1, err_sticky=1.
